divu_gen: RTL and testbench

- Parametrised successor to the SH on-chip divider.
- Performs signed or unsigned 2DW/DW and DW/DW division with BPS quotient bits resolved per CE_R step.
- Adds three things the previous unit lacks:
  - quotient-range overflow detection, not only a zero-divisor check;
  - an unsigned mode;
  - a configurable radix.
- Sits on the CPU internal bus (IBUS) at a parametrised base and raises an overflow interrupt with a programmable vector.

---
 rtl/divu_gen_if.sv | 21 ++
 rtl/divu_gen.sv | 185 ++++++++++++++++++
 tb/tb_divu_gen.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/divu_gen_if.sv
// IBUS slave bundle for the divu_gen divider.
// Address, data, lane and strobe signals plus the stall/decode responses.
interface divu_gen_if;
    logic [31:0] IBUS_A;
    logic [31:0] IBUS_DI;
    logic [31:0] IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;

    modport master (
        output IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
        input  IBUS_DO, IBUS_BUSY, IBUS_ACT
    );
    modport slave (
        input  IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
        output IBUS_DO, IBUS_BUSY, IBUS_ACT
    );
endinterface

// File: rtl/divu_gen.sv
// divu_gen: IBUS-mapped signed/unsigned 2DW/DW divider, BPS quotient bits per step.
// Optional DIVU_EARLY_OVF_EN: overflow found at load goes straight to DONE.
module divu_gen #(
    parameter int          DW   = 32,
    parameter int          BPS  = 1,
    parameter logic [31:0] BASE = 32'hFFFFFF00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE_R,
    input  logic       CE_F,
    input  logic       RES_N,
    divu_gen_if.slave  bus,
    output logic       IRQ,
    output logic [7:0] VEC
);
    localparam int NSTEP = DW / BPS;
    localparam int CW    = $clog2(NSTEP) + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_t;

    state_t          r_st;
    logic [DW-1:0]   r_dvsr, r_h, r_l;
    logic            r_ovf, r_ovfie, r_uns;
    logic [7:0]      r_vcr;
    logic [31:0]     r_rd;
    logic            r_busy;
    logic [DW-1:0]   r_rem, r_ql, r_dm, r_q, r_r;
    logic [CW-1:0]   r_cnt;
    logic            r_eovf, r_neg, r_rneg, r_uns_s, r_ovfie_s;

    logic [31:0]     w_off;
    logic            w_act, w_sel, w_idle, w_wr, w_start;
    logic [2:0]      w_idx;
    logic [DW-1:0]   w_di;
    logic [2*DW-1:0] w_nmag;
    logic [DW-1:0]   w_dmag;
    logic            w_sn, w_sd, w_lovf;
    logic [DW-1:0]   w_rem_n, w_ql_n, w_sat;
    logic [31:0]     w_rdmux;
    logic            w_unused;

    assign w_off   = bus.IBUS_A - BASE;
    assign w_act   = (w_off < 32'd32);
    assign w_sel   = bus.IBUS_REQ & w_act;
    assign w_idx   = w_off[4:2];
    assign w_idle  = (r_st == S_IDLE);
    assign w_wr    = CE_R & w_sel & bus.IBUS_WE & w_idle;
    assign w_start = w_wr & w_idx[0] & (w_idx != 3'd3);
    assign w_di    = bus.IBUS_DI[DW-1:0];

    assign w_sn   = ~r_uns & r_h[DW-1];
    assign w_sd   = ~r_uns & r_dvsr[DW-1];
    assign w_nmag = w_sn ? -{r_h, r_l} : {r_h, r_l};
    assign w_dmag = w_sd ? -r_dvsr : r_dvsr;
    assign w_lovf = (w_dmag == '0) | (w_nmag[2*DW-1:DW] >= w_dmag);
    assign w_sat  = r_uns_s ? {DW{1'b1}} : {r_neg, {(DW-1){~r_neg}}};

    // Quotient bits shift into r_ql as dividend bits shift out of it.
    always_comb begin
        logic [DW:0] w_t;
        w_t     = '0;
        w_rem_n = r_rem;
        w_ql_n  = r_ql;
        for (int i = 0; i < BPS; i++) begin
            w_t    = {w_rem_n, w_ql_n[DW-1]};
            w_ql_n = {w_ql_n[DW-2:0], (w_t >= {1'b0, r_dm})};
            if (w_ql_n[0])
                w_t = w_t - {1'b0, r_dm};
            w_rem_n = w_t[DW-1:0];
        end
    end

    always_comb begin
        w_rdmux = '0;
        case (w_idx)
            3'd0:       w_rdmux = 32'(r_dvsr);
            3'd2:       w_rdmux = {29'd0, r_uns, r_ovfie, r_ovf};
            3'd3:       w_rdmux = {24'd0, r_vcr};
            3'd4, 3'd6: w_rdmux = 32'(r_h);
            default:    w_rdmux = 32'(r_l);
        endcase
    end

    assign bus.IBUS_DO   = w_act ? r_rd : 32'd0;
    assign bus.IBUS_ACT  = w_act;
    assign bus.IBUS_BUSY = r_busy;
    assign IRQ           = r_ovf & r_ovfie;
    assign VEC           = r_vcr;
    assign w_unused      = ^{bus.IBUS_BA[3:1], bus.IBUS_DI, w_off[1:0]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_st  <= S_IDLE;
            r_dvsr <= '0; r_h <= '0; r_l <= '0;
            r_ovf <= 1'b0; r_ovfie <= 1'b0; r_uns <= 1'b0;
            r_vcr <= '0; r_rd <= '0; r_busy <= 1'b0;
            r_rem <= '0; r_ql <= '0; r_dm <= '0; r_q <= '0; r_r <= '0;
            r_cnt <= '0; r_eovf <= 1'b0; r_neg <= 1'b0; r_rneg <= 1'b0;
            r_uns_s <= 1'b0; r_ovfie_s <= 1'b0;
        end else if (CE_R && !RES_N) begin
            r_st  <= S_IDLE;
            r_dvsr <= '0; r_h <= '0; r_l <= '0;
            r_ovf <= 1'b0; r_ovfie <= 1'b0; r_uns <= 1'b0;
            r_vcr <= '0; r_rd <= '0; r_busy <= 1'b0;
            r_rem <= '0; r_ql <= '0; r_dm <= '0; r_q <= '0; r_r <= '0;
            r_cnt <= '0; r_eovf <= 1'b0; r_neg <= 1'b0; r_rneg <= 1'b0;
            r_uns_s <= 1'b0; r_ovfie_s <= 1'b0;
        end else begin
            if (CE_F && w_sel && !bus.IBUS_WE && w_idle)
                r_rd <= w_rdmux;
            if (CE_R) begin
                if (w_sel)
                    r_busy <= !w_idle;
                case (r_st)
                    S_IDLE: begin
                        if (w_wr) begin
                            case (w_idx)
                                3'd0: r_dvsr <= w_di;
                                3'd1: begin
                                    r_l <= w_di;
                                    r_h <= r_uns ? '0 : {DW{w_di[DW-1]}};
                                end
                                3'd2: if (bus.IBUS_BA[0]) begin
                                    r_ovf   <= r_ovf & w_di[0];
                                    r_ovfie <= w_di[1];
                                    r_uns   <= w_di[2];
                                end
                                3'd3: if (bus.IBUS_BA[0])
                                    r_vcr <= bus.IBUS_DI[7:0];
                                3'd4, 3'd6: r_h <= w_di;
                                default: r_l <= w_di;
                            endcase
                        end
                        if (w_start)
                            r_st <= S_LOAD;
                    end
                    S_LOAD: begin
                        r_rem     <= w_nmag[2*DW-1:DW];
                        r_ql      <= w_nmag[DW-1:0];
                        r_dm      <= w_dmag;
                        r_neg     <= w_sn ^ w_sd;
                        r_rneg    <= w_sn;
                        r_uns_s   <= r_uns;
                        r_ovfie_s <= r_ovfie;
                        r_eovf    <= w_lovf;
                        r_cnt     <= '0;
`ifdef DIVU_EARLY_OVF_EN
                        r_st <= w_lovf ? S_DONE : S_ITER;
`else
                        r_st <= S_ITER;
`endif
                    end
                    S_ITER: begin
                        r_rem <= w_rem_n;
                        r_ql  <= w_ql_n;
                        if (r_cnt == CW'(NSTEP - 1))
                            r_st <= S_FIX;
                        else
                            r_cnt <= r_cnt + 1'b1;
                    end
                    S_FIX: begin
                        r_q <= r_neg ? -r_ql : r_ql;
                        r_r <= r_rneg ? -r_rem : r_rem;
                        // Signed quotient must fit in DW bits two's complement.
                        r_eovf <= r_eovf | (~r_uns_s & r_ql[DW-1] &
                                  (~r_neg | (|r_ql[DW-2:0])));
                        r_st <= S_DONE;
                    end
                    S_DONE: begin
                        if (!r_eovf) begin
                            r_l <= r_q;
                            r_h <= r_r;
                        end else if (!r_ovfie_s) begin
                            r_l <= w_sat;
                        end
                        r_ovf <= r_ovf | r_eovf;
                        r_st  <= S_IDLE;
                    end
                    default: r_st <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_divu_gen.sv
// Scoreboard bench for divu_gen (DW=32, BPS=2): a register-level model
// predicts read data, IRQ/VEC and BUSY; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_divu_gen;
    localparam logic [31:0] BASE = 32'hFFFFFF00;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CE_R = 1'b1;
    logic       CE_F = 1'b1;
    logic       RES_N = 1'b1;
    logic       IRQ;
    logic [7:0] VEC;

    divu_gen_if bus();

    divu_gen #(.DW(32), .BPS(2), .BASE(BASE)) dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
        .bus(bus), .IRQ(IRQ), .VEC(VEC)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [31:0] m_dvsr, m_h, m_l, m_vcr, m_last;
    logic        m_ovf, m_ovfie, m_uns;
    int          lat;
    bit          early;

    initial begin : monitor
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge CLK);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.kind)
                    0:       act = bus.IBUS_DO;
                    1:       act = {31'd0, bus.IBUS_BUSY};
                    2:       act = {31'd0, IRQ};
                    default: act = {24'd0, VEC};
                endcase
                n_chk++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic expect_(input int k, input logic [31:0] v, input string nm);
        sb_q.push_back('{k, v, nm});
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic acc(input logic [4:0] off, input logic we, input logic [31:0] d);
        bus.IBUS_A   = BASE + 32'(off);
        bus.IBUS_DI  = d;
        bus.IBUS_WE  = we;
        bus.IBUS_BA  = 4'hF;
        bus.IBUS_REQ = 1'b1;
        @(posedge CLK);
        #1;
        bus.IBUS_REQ = 1'b0;
        bus.IBUS_WE  = 1'b0;
    endtask

    task automatic rd(input logic [4:0] off, input logic [31:0] v, input string nm);
        acc(off, 1'b0, 32'd0);
        expect_(0, v, nm);
        m_last = v;
        settle();
    endtask

    task automatic model_clear();
        m_dvsr = 0; m_h = 0; m_l = 0; m_vcr = 0; m_last = 0;
        m_ovf = 0; m_ovfie = 0; m_uns = 0;
    endtask

    // Whole-number division on the 64-bit dividend; overflow when the
    // quotient does not fit the 32-bit result type of the current mode.
    task automatic model_start();
        logic [63:0] n, nm, dm, qm, rm;
        logic        sn, sd, neg, ovf;
        logic [31:0] q, r, sat;
        n   = {m_h, m_l};
        sn  = !m_uns && m_h[31];
        sd  = !m_uns && m_dvsr[31];
        neg = sn ^ sd;
        nm  = sn ? -n : n;
        dm  = sd ? {32'd0, -m_dvsr} : {32'd0, m_dvsr};
        ovf = 1'b0;
        q   = 0;
        r   = 0;
        if (dm == 0) begin
            ovf = 1'b1;
        end else begin
            qm = nm / dm;
            rm = nm % dm;
            if (qm > 64'hFFFF_FFFF)
                ovf = 1'b1;
            else if (!m_uns && (neg ? qm > 64'h8000_0000 : qm > 64'h7FFF_FFFF))
                ovf = 1'b1;
            q = neg ? -qm[31:0] : qm[31:0];
            r = sn ? -rm[31:0] : rm[31:0];
        end
        sat = m_uns ? 32'hFFFF_FFFF : (neg ? 32'h8000_0000 : 32'h7FFF_FFFF);
        if (!ovf) begin
            m_l = q;
            m_h = r;
        end else if (!m_ovfie) begin
            m_l = sat;
        end
        m_ovf = m_ovf | ovf;
        lat = (early && ovf) ? 2 : 19;
    endtask

    task automatic set_dvsr(input logic [31:0] v);
        m_dvsr = v;
        acc(5'h00, 1'b1, v);
    endtask

    task automatic set_dvcr(input logic [31:0] v);
        m_ovf   = m_ovf & v[0];
        m_ovfie = v[1];
        m_uns   = v[2];
        acc(5'h08, 1'b1, v);
    endtask

    task automatic set_vcr(input logic [31:0] v);
        m_vcr = {24'd0, v[7:0]};
        acc(5'h0C, 1'b1, v);
    endtask

    task automatic set_h(input logic [31:0] v);
        m_h = v;
        acc(5'h10, 1'b1, v);
    endtask

    task automatic start32(input logic [31:0] v);
        m_l = v;
        m_h = m_uns ? 32'd0 : {32{v[31]}};
        model_start();
        acc(5'h04, 1'b1, v);
    endtask

    task automatic start64(input logic [4:0] off, input logic [31:0] v);
        m_l = v;
        model_start();
        acc(off, 1'b1, v);
    endtask

    task automatic check_all();
        rd(5'h00, m_dvsr, "DVSR");
        rd(5'h04, m_l, "DVDNT");
        rd(5'h08, {29'd0, m_uns, m_ovfie, m_ovf}, "DVCR");
        rd(5'h0C, m_vcr, "VCRDIV");
        rd(5'h10, m_h, "DVDNTH");
        rd(5'h14, m_l, "DVDNTL");
        rd(5'h18, m_h, "DVDNTH_mirror");
        rd(5'h1C, m_l, "DVDNTL_mirror");
        expect_(2, {31'd0, m_ovf & m_ovfie}, "IRQ");
        expect_(3, m_vcr, "VEC");
        settle();
        n_chk++;
        if (IRQ !== (m_ovf & m_ovfie)) begin
            n_fail++;
            $display("FAIL IRQ_direct: got %b expected %b", IRQ, m_ovf & m_ovfie);
        end
        n_chk++;
        if (VEC !== m_vcr[7:0]) begin
            n_fail++;
            $display("FAIL VEC_direct: got %h expected %h", VEC, m_vcr[7:0]);
        end
    endtask

    // Probe the DONE edge (still busy) and the edge after it (idle again).
    task automatic done_check();
        idle(lat - 1);
        acc(5'h00, 1'b0, 32'd0);
        expect_(1, 32'd1, "busy_at_done");
        settle();
        rd(5'h00, m_dvsr, "dvsr_after_done");
        expect_(1, 32'd0, "busy_after_done");
        settle();
    endtask

    initial begin
`ifdef DIVU_EARLY_OVF_EN
        early = 1'b1;
`else
        early = 1'b0;
`endif
        lat = 19;
        bus.IBUS_A = 0; bus.IBUS_DI = 0; bus.IBUS_BA = 0;
        bus.IBUS_WE = 0; bus.IBUS_REQ = 0;
        model_clear();
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        expect_(1, 32'd0, "busy_reset");
        settle();
        check_all();

        // signed -7 / 3
        set_dvcr(32'h0);
        set_dvsr(32'd3);
        start32(32'hFFFF_FFF9);
        done_check();
        check_all();

        bus.IBUS_A = 32'h0000_1000;
        expect_(0, 32'd0, "do_unselected");
        settle();

        // 64/32 start with mid-operation read and DVSR write
        set_h(32'd0);
        set_dvsr(32'h10);
        start64(5'h14, 32'h100);
        idle(3);
        acc(5'h00, 1'b0, 32'd0);
        expect_(1, 32'd1, "busy_midop");
        expect_(0, m_last, "rd_stale_midop");
        settle();
        acc(5'h00, 1'b1, 32'h55);
        idle(lat - 5);
        check_all();

        // unsigned 0xFFFFFFFE / 2
        set_dvcr(32'h4);
        set_dvsr(32'd2);
        start32(32'hFFFF_FFFE);
        idle(lat);
        check_all();

        // divide by zero, saturate then keep
        set_dvcr(32'h0);
        set_dvsr(32'd0);
        start32(32'd5);
        done_check();
        check_all();
        set_dvcr(32'h2);
        set_vcr(32'h5A);
        start32(32'd5);
        idle(lat);
        check_all();
        set_dvcr(32'h3);
        check_all();
        set_dvcr(32'h2);
        check_all();

        // signed range overflow vs unsigned
        set_dvcr(32'h0);
        set_h(32'd0);
        set_dvsr(32'd1);
        start64(5'h14, 32'h8000_0000);
        idle(lat);
        check_all();
        set_dvcr(32'h4);
        set_h(32'd0);
        start64(5'h1C, 32'h8000_0000);
        idle(lat);
        check_all();

        // soft reset
        set_vcr(32'h77);
        RES_N = 1'b0;
        idle(1);
        RES_N = 1'b1;
        model_clear();
        check_all();

        // async reset during iteration
        set_dvsr(32'd7);
        set_vcr(32'h33);
        start32(32'd100);
        idle(2);
        acc(5'h00, 1'b0, 32'd0);
        expect_(1, 32'd1, "busy_before_rst");
        settle();
        idle(2);
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        model_clear();
        n_chk++;
        if (bus.IBUS_BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_rst_direct: got %b expected 0", bus.IBUS_BUSY);
        end
        expect_(1, 32'd0, "busy_after_rst");
        expect_(3, 32'd0, "vec_after_rst");
        settle();
        check_all();
        set_dvsr(32'd9);
        start32(32'd50);
        done_check();
        check_all();

        // randomized operations
        for (int it = 0; it < 30; it++) begin
            logic [31:0] d, v, h;
            set_dvcr(32'($urandom_range(0, 7)));
            set_vcr(32'($urandom_range(0, 255)));
            case ($urandom_range(0, 7))
                0:       d = 32'd0;
                1, 2, 3: begin
                    d = 32'($urandom_range(1, 40));
                    if ($urandom_range(0, 1) == 1)
                        d = -d;
                end
                default: d = $urandom;
            endcase
            set_dvsr(d);
            v = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                start32(v);
            end else begin
                h = ($urandom_range(0, 1) == 1) ? $urandom
                    : ($urandom >> $urandom_range(8, 31));
                set_h(h);
                start64(it[0] ? 5'h14 : 5'h1C, v);
            end
            idle(lat);
            check_all();
        end

        idle(2);
        if (n_chk < 12) begin
            n_fail++;
            $display("FAIL too few checks: %0d", n_chk);
        end
        if (n_fail != 0)
            $display("FAIL summary: %0d failures", n_fail);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
